// File: rtl/pwm_sdr_pkg.sv
// Shared types and default constants for the symbol framing path.
// Holds the framer state enumeration and the checksum fold helper.
package pwm_sdr_pkg;

  localparam int DATA_W = 8;

  localparam logic signed [DATA_W-1:0] SYNC_SYMBOL_DEF = 8'sd10;
  localparam int PAYLOAD_LEN_DEF = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } framer_state_t;

  // Frame checksum is a plain XOR of the two's-complement symbol bytes.
  function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                  input logic signed [DATA_W-1:0] sym);
    return acc ^ $unsigned(sym);
  endfunction

endpackage

// File: rtl/symbol_framer_if.sv
// Symbol input / framed payload output bundle between decoder, framer and consumer.
interface symbol_framer_if;
  import pwm_sdr_pkg::*;

  logic signed [DATA_W-1:0] sym_in;
  logic                     sym_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;
  logic                     frame_ok;
  logic                     frame_err;
  logic                     overflow;
  logic [4:0]               fifo_level;

  modport master (
    output sym_in, sym_valid, out_ready,
    input  out_data, out_valid, out_last, frame_ok, frame_err, overflow, fifo_level
  );

  modport slave (
    input  sym_in, sym_valid, out_ready,
    output out_data, out_valid, out_last, frame_ok, frame_err, overflow, fifo_level
  );

endinterface

// File: rtl/symbol_fifo.sv
// Payload FIFO with a separate commit pointer: writes stay tentative until
// committed, and a rewind drops everything written since the last commit.
module symbol_fifo
  import pwm_sdr_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_sym,
  input  logic                     wr_last,
  input  logic                     commit,
  input  logic                     rewind,
  input  logic                     rd_en,
  output logic                     full,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_sym,
  output logic                     rd_last,
  output logic [PW-1:0]            level
);

  localparam int AW = PW - 1;

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   cm_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DATA_W:0] head;

  // Full counts tentative entries too, and uses the read pointer before any pop.
  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign rd_valid = cm_ptr != rd_ptr;
  assign level    = cm_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_sym   = rd_valid ? $signed(head[DATA_W-1:0]) : '0;
  assign rd_last  = rd_valid & head[DATA_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rewind)
        wr_ptr <= cm_ptr;
      else if (wr_en && !full)
        wr_ptr <= wr_ptr + PW'(1);
      if (commit)
        cm_ptr <= wr_ptr;
      if (rd_en && rd_valid)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= {wr_last, wr_sym};
  end

endmodule

// File: rtl/symbol_framer.sv
// Finds sync symbols, collects a fixed-length payload, and commits it to the
// output FIFO only when the trailing XOR checksum matches.
module symbol_framer
  import pwm_sdr_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] SYNC_SYMBOL = SYNC_SYMBOL_DEF,
  parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clock,
  input  logic            reset,
  symbol_framer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  framer_state_t state;
  framer_state_t state_nxt;

  logic [2:0]               idx;
  logic [DATA_W-1:0]        csum;
  logic                     is_sync;
  logic                     idx_last;
  logic                     sum_match;

  logic                     wr_en;
  logic                     wr_last;
  logic                     commit;
  logic                     rewind;
  logic                     ok_nxt;
  logic                     err_nxt;
  logic                     ovf_nxt;
  logic                     ok_p1;
  logic                     err_p1;
  logic                     ovf_p1;

  logic                     full;
  logic                     rd_valid;
  logic                     rd_last;
  logic signed [DATA_W-1:0] rd_sym;
  logic [PW-1:0]            level;

  assign is_sync   = bus.sym_valid && (bus.sym_in == SYNC_SYMBOL);
  assign idx_last  = idx == 3'(PAYLOAD_LEN - 1);
  assign sum_match = csum == $unsigned(bus.sym_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:
        if (is_sync)
          state_nxt = PAYLOAD;
      PAYLOAD:
        if (bus.sym_valid) begin
          if (full)
            state_nxt = HUNT;
          else if (idx_last)
            state_nxt = CHECK;
        end
      CHECK:
        if (bus.sym_valid)
          state_nxt = HUNT;
      default:
        state_nxt = HUNT;
    endcase
  end

  // Sync symbols only matter in HUNT; inside a frame they are ordinary data.
  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    commit  = 1'b0;
    rewind  = 1'b0;
    ok_nxt  = 1'b0;
    err_nxt = 1'b0;
    ovf_nxt = 1'b0;
    case (state)
      PAYLOAD:
        if (bus.sym_valid) begin
          if (full) begin
            rewind  = 1'b1;
            ovf_nxt = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_last = idx_last;
          end
        end
      CHECK:
        if (bus.sym_valid) begin
          if (sum_match) begin
            commit = 1'b1;
            ok_nxt = 1'b1;
          end else begin
            rewind  = 1'b1;
            err_nxt = 1'b1;
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      csum <= '0;
    end else if (state == HUNT && is_sync) begin
      idx  <= '0;
      csum <= '0;
    end else if (wr_en) begin
      idx  <= idx + 3'd1;
      csum <= csum_fold(csum, bus.sym_in);
    end
  end

  // Status pulses land on the same cycle the committed data becomes visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ok_p1  <= 1'b0;
      err_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
    end else begin
      ok_p1  <= ok_nxt;
      err_p1 <= err_nxt;
      ovf_p1 <= ovf_nxt;
    end
  end

  symbol_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sym   (bus.sym_in),
    .wr_last  (wr_last),
    .commit   (commit),
    .rewind   (rewind),
    .rd_en    (bus.out_ready),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_sym   (rd_sym),
    .rd_last  (rd_last),
    .level    (level)
  );

  assign bus.out_data   = rd_sym;
  assign bus.out_valid  = rd_valid;
  assign bus.out_last   = rd_last;
  assign bus.frame_ok   = ok_p1;
  assign bus.frame_err  = err_p1;
  assign bus.overflow   = ovf_p1;
  assign bus.fifo_level = 5'(level);

endmodule

// File: doc/symbol_framer.md
SYMBOL_FRAMER -- requirements
Module: symbol_framer

Interface
REQ-001 Parameter SYNC_SYMBOL, default 8'sd10: signed symbol value that marks a frame start.
REQ-002 Parameter PAYLOAD_LEN, default 4: payload symbols per frame, legal range 1..8.
REQ-003 Parameter DEPTH, default 16: output FIFO entries, power of two, DEPTH >= PAYLOAD_LEN.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port sym_in, input, 8 signed: decoded symbol from decoder_top.
REQ-007 Port sym_valid, input, 1: sym_in is valid this cycle; one symbol is consumed per asserted cycle.
REQ-008 Port out_data, output, 8 signed: head-of-FIFO payload symbol.
REQ-009 Port out_valid, output, 1: out_data holds a committed symbol.
REQ-010 Port out_last, output, 1: out_data is the final payload symbol of its frame.
REQ-011 Port out_ready, input, 1: consumer accepts out_data when it is high in the same cycle as out_valid.
REQ-012 Port frame_ok, output, 1: one-cycle pulse when a frame is committed.
REQ-013 Port frame_err, output, 1: one-cycle pulse when a checksum mismatch causes a frame to be discarded.
REQ-014 Port overflow, output, 1: one-cycle pulse when FIFO space runs out and a frame is aborted.
REQ-015 Port fifo_level, output, 5: number of committed entries, 0..DEPTH.

Function
REQ-016 The FSM SHALL have three states: HUNT, PAYLOAD and CHECK.
REQ-017 In HUNT, a valid symbol equal to SYNC_SYMBOL SHALL move the FSM to PAYLOAD and clear the index and the checksum; every other symbol SHALL be ignored.
REQ-018 In PAYLOAD, each valid symbol SHALL be written tentatively at the write pointer and XORed into the 8-bit checksum.
REQ-019 The FIFO entry written with index PAYLOAD_LEN-1 SHALL carry the last flag, and the FSM SHALL then move to CHECK.
REQ-020 In CHECK, the next valid symbol SHALL be compared with the checksum:
  - on a match, the commit pointer advances to the write pointer, frame_ok pulses and the FSM returns to HUNT;
  - on a mismatch, the write pointer rewinds to the commit pointer, frame_err pulses and the FSM returns to HUNT.
REQ-021 A valid symbol equal to SYNC_SYMBOL received in PAYLOAD or CHECK SHALL be treated as data, not as a resynchronisation.
REQ-022 Only committed entries SHALL be visible to the read side; tentative entries SHALL never drive out_valid.
REQ-023 Committed entries SHALL become visible (out_valid, fifo_level) on the cycle after the commit edge.
REQ-024 FIFO full SHALL mean (write pointer - read pointer) == DEPTH.
  - A payload write attempted while full SHALL pulse overflow, rewind the write pointer to the commit pointer and return the FSM to HUNT.
REQ-025 A read and a tentative write in the same cycle SHALL both take effect; the full test SHALL use the pre-read pointer value.
REQ-026 Pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-027 out_data and out_last SHALL be driven combinationally from the read pointer; fifo_level SHALL equal the commit pointer minus the read pointer.

Reset
REQ-028 Reset SHALL asynchronously set the FSM to HUNT and clear every pointer, the index and the checksum.
REQ-029 During reset, out_valid, out_last, frame_ok, frame_err, overflow and fifo_level SHALL all be 0; out_data SHALL be 0.
REQ-030 Reset in the middle of a frame SHALL discard all entries, committed and tentative.

Structure
REQ-031 The state enumeration and the default SYNC_SYMBOL, PAYLOAD_LEN and DEPTH constants SHALL live in the shared package pwm_sdr_pkg.
REQ-032 Storage SHALL be implemented in one sub-module, symbol_fifo.
  - symbol_fifo holds 9-bit entries (symbol plus last flag) and provides tentative-write, commit and rewind controls.

Verification
REQ-033 Sync 10, then 1,2,3,4, then checksum 4 -> frame_ok pulse; out sequence 1,2,3,4 with out_last on 4; fifo_level reaches 4.
REQ-034 Sync 10, then 1,2,3,4, then checksum 5 -> frame_err pulse; out_valid stays 0; fifo_level stays 0.
REQ-035 Symbols 7,-3,0 before sync 10 -> ignored; the frame that follows commits normally.
REQ-036 out_ready held 0 while four good frames are sent -> fifo_level 16; the first payload symbol of a fifth frame -> overflow pulse, FSM in HUNT, level stays 16.
REQ-037 Reset asserted after sync 10, 1, 2 -> all outputs 0; the next full frame commits normally.
REQ-038 out_ready=1 during back-to-back frames -> symbols drain in order with no loss or duplication, and out_last appears once per frame.
